// File: rtl/serial_subtractor_ctrl_pkg.sv
// rtl/serial_subtractor_ctrl_pkg.sv - shared FSM encoding for the bit-serial subtractor
package serial_subtractor_ctrl_pkg;

  // Controller states: waiting for start, stepping bits, presenting result
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/serial_subtractor_ctrl_full_subtractor.sv
// rtl/serial_subtractor_ctrl_full_subtractor.sv - 1-bit full subtractor cell (a - b - c)
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic borrow,
  output logic diff
);

  // Borrow when b exceeds a, or when a equals b and a borrow is pending
  always_comb begin
    diff   = a ^ b ^ c;
    borrow = (~a & b) | (~(a ^ b) & c);
  end

endmodule

// File: rtl/serial_subtractor_ctrl.sv
// rtl/serial_subtractor_ctrl.sv - bit-serial WIDTH-bit subtractor controller, LSB first
module serial_subtractor_ctrl
  import serial_subtractor_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_sh_q, b_sh_q, d_sh_q;
  logic [WIDTH-1:0] a_sh_d, b_sh_d, d_sh_d;
  logic             brw_q;
  logic             busy_q, done_q, bout_q;
  logic [WIDTH-1:0] diff_q;
  logic             cell_borrow, cell_diff;

  full_subtractor u_cell (
    .a      (a_sh_q[0]),
    .b      (b_sh_q[0]),
    .c      (brw_q),
    .borrow (cell_borrow),
    .diff   (cell_diff)
  );

  // Next values of the working shift registers for one bit step
  always_comb begin
    a_sh_d = a_sh_q >> 1;
    b_sh_d = b_sh_q >> 1;
    d_sh_d = WIDTH'({cell_diff, d_sh_q} >> 1);
  end

  // Controller FSM with registered handshake and result outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      d_sh_q  <= '0;
      brw_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            a_sh_q  <= a;
            b_sh_q  <= b;
            brw_q   <= bin;
            d_sh_q  <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          if (abort) begin
            // Abandon the operation; the previous result stays on diff/bout
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            a_sh_q <= a_sh_d;
            b_sh_q <= b_sh_d;
            d_sh_q <= d_sh_d;
            brw_q  <= cell_borrow;
            cnt_q  <= cnt_q + CW'(1);
            if (cnt_q == LAST) begin
              diff_q  <= d_sh_d;
              bout_q  <= cell_borrow;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign diff = diff_q;
  assign bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// tb/tb_serial_subtractor_ctrl.sv - scoreboard bench for the bit-serial subtractor
module tb_serial_subtractor_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       start, abort, bin, busy, done, bout;
  logic [7:0] a, b, diff;
  logic       start4, abort4, bin4, busy4, done4, bout4;
  logic [3:0] a4, b4, diff4;

  typedef struct packed { logic [7:0] d; logic bo; } exp8_t;
  typedef struct packed { logic [3:0] d; logic bo; } exp4_t;
  exp8_t q8[$];
  exp4_t q4[$];
  exp8_t e8;
  exp4_t e4;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int d0;

  serial_subtractor_ctrl #(.WIDTH(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .a(a), .b(b), .bin(bin),
    .busy(busy), .done(done), .diff(diff), .bout(bout)
  );

  serial_subtractor_ctrl #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .abort(abort4), .a(a4), .b(b4), .bin(bin4),
    .busy(busy4), .done(done4), .diff(diff4), .bout(bout4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard for the 8-bit instance: every done pops one expected result
  always @(negedge clk) begin
    if (done === 1'b1) begin
      done_cnt++;
      if (q8.size() == 0) check("unexpected_done8", 32'd1, 32'd0);
      else begin
        e8 = q8.pop_front();
        check("diff8", {24'd0, diff}, {24'd0, e8.d});
        check("bout8", {31'd0, bout}, {31'd0, e8.bo});
      end
    end
  end

  // Scoreboard for the 4-bit instance
  always @(negedge clk) begin
    if (done4 === 1'b1) begin
      if (q4.size() == 0) check("unexpected_done4", 32'd1, 32'd0);
      else begin
        e4 = q4.pop_front();
        check("diff4", {28'd0, diff4}, {28'd0, e4.d});
        check("bout4", {31'd0, bout4}, {31'd0, e4.bo});
      end
    end
  end

  task automatic op8(input logic [7:0] ta, input logic [7:0] tb, input logic tbin, input bit push);
    logic [8:0] t;
    @(negedge clk);
    a = ta; b = tb; bin = tbin; start = 1'b1;
    t = {1'b0, ta} - {1'b0, tb} - {8'd0, tbin};
    if (push) q8.push_back('{t[7:0], t[8]});
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait8();
    int n = 0;
    while (done !== 1'b1 && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (n >= 30) check("timeout8", 32'd0, 32'd1);
    @(negedge clk);
  endtask

  task automatic op4(input logic [3:0] ta, input logic [3:0] tb, input logic tbin);
    logic [4:0] t;
    int n;
    @(negedge clk);
    a4 = ta; b4 = tb; bin4 = tbin; start4 = 1'b1;
    t = {1'b0, ta} - {1'b0, tb} - {4'd0, tbin};
    q4.push_back('{t[3:0], t[4]});
    @(negedge clk);
    start4 = 1'b0;
    n = 0;
    while (done4 !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check("timeout4", 32'd0, 32'd1);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 0; abort = 0; bin = 0; a = '0; b = '0;
    start4 = 0; abort4 = 0; bin4 = 0; a4 = '0; b4 = '0;
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_diff", {24'd0, diff}, 32'd0);
    check("rst_bout", {31'd0, bout}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Case 1 + 4: latency profile, with a second start ignored during RUN
    d0 = done_cnt;
    @(negedge clk);
    a = 8'h5A; b = 8'h3C; bin = 1'b0; start = 1'b1;
    q8.push_back('{8'h1E, 1'b0});
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      start = (i == 3 || i == 4);
      if (start) begin a = 8'h01; b = 8'h01; end
      check("busy_lat", {31'd0, busy}, {31'd0, (i <= 9)});
      check("done_lat", {31'd0, done}, {31'd0, (i == 9)});
    end
    check("one_done", done_cnt - d0, 32'd1);
    check("diff_hold", {24'd0, diff}, 32'h1E);

    // Cases 2 and 3: wrap and borrow-in
    op8(8'h00, 8'h01, 1'b0, 1'b1); wait8();
    op8(8'h10, 8'h10, 1'b1, 1'b1); wait8();
    op8(8'hFF, 8'h00, 1'b0, 1'b1); wait8();

    // Case 5: abort in the 4th RUN cycle after a 0x1E result
    op8(8'h5A, 8'h3C, 1'b0, 1'b1); wait8();
    d0 = done_cnt;
    op8(8'h00, 8'h01, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_diff", {24'd0, diff}, 32'h1E);
    repeat (12) @(negedge clk);
    check("abort_nodone", done_cnt - d0, 32'd0);
    check("abort_diff2", {24'd0, diff}, 32'h1E);
    op8(8'hFF, 8'h00, 1'b0, 1'b1); wait8();

    // Case 6: asynchronous reset mid-RUN
    op8(8'h33, 8'h11, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_done", {31'd0, done}, 32'd0);
    check("arst_diff", {24'd0, diff}, 32'd0);
    check("arst_bout", {31'd0, bout}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    op8(8'h5A, 8'h3C, 1'b0, 1'b1); wait8();

    // Exhaustive 4-bit sweep against a - b - bin
    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++)
        for (int c = 0; c < 2; c++)
          op4(4'(x), 4'(y), 1'(c));

    check("q8_empty", q8.size(), 32'd0);
    check("q4_empty", q4.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
